multimem_reader: RTL and testbench



---
 rtl/multimem_reader_if.sv | 33 +++
 rtl/multimem_reader.sv | 138 +++++++++++++
 tb/tb_multimem_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/multimem_reader_if.sv
// multimem_reader_if - port-B RAM bus plus pixel stream of the frame reader.
//   ram_b_address/ram_b_clk_enable/ram_b_reset : reader -> RAM port B
//   ram_b_data_out                             : RAM QB -> reader
//   pix_data/pix_valid/pix_last                : reader -> panel driver
//   pix_ready                                  : panel driver -> reader
// master = reader side, slave = RAM/consumer side.
interface multimem_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_b_address;
  logic              ram_b_clk_enable;
  logic              ram_b_reset;
  logic [DATA_W-1:0] ram_b_data_out;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;

  modport master (
    output ram_b_address, ram_b_clk_enable, ram_b_reset,
    input  ram_b_data_out,
    output pix_data, pix_valid, pix_last,
    input  pix_ready
  );

  modport slave (
    input  ram_b_address, ram_b_clk_enable, ram_b_reset,
    output ram_b_data_out,
    input  pix_data, pix_valid, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/multimem_reader.sv
// multimem_reader - sequential frame reader for port B of the multimem framebuffer.
// On start (IDLE only) walks ROWS*WORDS_PER_ROW words from a latched base address,
// hides the one-cycle RAM latency behind a credit-gated 4-entry FIFO and streams
// words out on a valid/ready interface.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   start, abort    : frame request / synchronous cancel (abort wins)
//   base_addr       : first word address, latched on accepted start
//   frame_done      : one-cycle pulse after the final word is accepted
//   busy            : frame in progress
//   bus (master)    : port-B RAM signals and pixel stream
// Build option: define MULTIMEM_READER_BYTESWAP_EN to swap bytes of each captured word.
module multimem_reader #(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 16,
  parameter int ROWS          = 32,
  parameter int WORDS_PER_ROW = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              frame_done,
  output logic              busy,
  multimem_reader_if.master bus
);
  localparam int N     = ROWS * WORDS_PER_ROW;
  localparam int IDX_W = $clog2(N + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  // [0]: read issued, RAM samples next edge; [1]: QB valid, captured next edge
  logic [1:0]        vld_pipe;
  logic [1:0]        last_pipe;

  logic [DATA_W-1:0] fifo_data [4];
  logic [3:0]        fifo_last;
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        fifo_count;

  logic              start_ok, run_issue, issue, credit_ok, push, pop, drain_done;
  logic              issue_last;
  logic [IDX_W-1:0]  issue_idx, next_idx;
  logic [ADDR_W-1:0] issue_addr;
  logic [2:0]        inflight;
  logic [DATA_W-1:0] cap_data;

  always_comb begin
    inflight   = {2'b00, vld_pipe[0]} + {2'b00, vld_pipe[1]};
    // every issued read already owns a FIFO slot, so pushes can never overflow
    credit_ok  = (fifo_count + inflight) < 3'd4;
    start_ok   = (state == IDLE) && start && !abort;
    run_issue  = (state == RUN) && credit_ok && !abort;
    issue      = start_ok || run_issue;
    issue_idx  = start_ok ? '0 : idx;
    next_idx   = issue_idx + IDX_W'(1);
    // modulo 2^ADDR_W wrap falls out of the truncating add
    issue_addr = (start_ok ? base_addr : base_q) + ADDR_W'(issue_idx);
    issue_last = (int'(issue_idx) % WORDS_PER_ROW) == (WORDS_PER_ROW - 1);
    push       = vld_pipe[1];
    pop        = bus.pix_valid && bus.pix_ready;
    // done on the edge that takes the final word (empty-FIFO case as a fallback)
    drain_done = (state == DRAIN) && (vld_pipe == 2'b00) &&
                 ((fifo_count == 3'd0) || ((fifo_count == 3'd1) && pop));
  end

`ifdef MULTIMEM_READER_BYTESWAP_EN
  assign cap_data = {bus.ram_b_data_out[7:0], bus.ram_b_data_out[DATA_W-1:8]};
`else
  assign cap_data = bus.ram_b_data_out;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      frame_done <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      frame_done <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[0], issue};
      last_pipe  <= {last_pipe[0], issue && issue_last};
      frame_done <= drain_done;
      if (start_ok) base_q <= base_addr;
      if (issue) begin
        addr_q <= issue_addr;
        idx    <= next_idx;
        state  <= (next_idx == IDX_W'(N)) ? DRAIN : RUN;
      end else if (drain_done) begin
        state  <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
      fifo_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= cap_data;
        fifo_last[wr_ptr] <= last_pipe[1];
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + 3'(push) - 3'(pop);
    end
  end

  assign busy                 = (state != IDLE);
  assign bus.ram_b_address    = addr_q;
  assign bus.ram_b_clk_enable = vld_pipe[0];
  assign bus.ram_b_reset      = 1'b0;
  assign bus.pix_valid        = (fifo_count != 3'd0);
  assign bus.pix_data         = fifo_data[rd_ptr];
  assign bus.pix_last         = bus.pix_valid && fifo_last[rd_ptr];
endmodule

// File: tb/tb_multimem_reader.sv
// Directed bench for multimem_reader with a 2x4-word frame and a behavioural
// port-B RAM (one-cycle read latency).
module tb_multimem_reader;
  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [10:0] base_addr;
  logic        frame_done, busy;
  logic [15:0] mem [2048];
  int          n_chk = 0, n_pass = 0;

  multimem_reader_if #(.ADDR_W(11), .DATA_W(16)) bus ();

  multimem_reader #(.ADDR_W(11), .DATA_W(16), .ROWS(2), .WORDS_PER_ROW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
    .frame_done(frame_done), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.ram_b_clk_enable) bus.ram_b_data_out <= mem[bus.ram_b_address];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // mode 0: ready=1; mode 1: ready toggles, stray start mid-frame; mode 2: ready=0 for 12 cycles
  task automatic run_frame(input logic [10:0] b, input int mode, input string tag);
    int got, issued, max_out, data_err, addr_err, hold_err;
    bit fd, prev_stall;
    logic [15:0] prev_d;
    logic [10:0] a;
    got = 0; issued = 0; max_out = 0; data_err = 0; addr_err = 0; hold_err = 0;
    fd = 0; prev_stall = 0; prev_d = '0;
    start = 1'b1; base_addr = b; bus.pix_ready = (mode == 0);
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !fd; cyc++) begin
      if (frame_done) fd = 1;
      else begin
        if (bus.ram_b_clk_enable) begin
          a = b + 11'(issued);
          if (bus.ram_b_address !== a) addr_err++;
          issued++;
        end
        if (prev_stall && (bus.pix_data !== prev_d || bus.pix_valid !== 1'b1)) hold_err++;
        if (mode == 0) bus.pix_ready = 1'b1;
        else if (mode == 1) bus.pix_ready = (cyc % 2 == 1);
        else bus.pix_ready = (cyc >= 12);
        if (mode == 1 && cyc == 5) begin start = 1'b1; base_addr = 11'h300; end
        if (mode == 1 && cyc == 6) begin start = 1'b0; base_addr = b; end
        if (mode == 2 && cyc == 11) begin
          chk({tag, "_stall_en"}, 32'(bus.ram_b_clk_enable), 32'd0);
          chk({tag, "_stall_outstanding"}, 32'(issued - got), 32'd4);
        end
        if (bus.pix_valid && bus.pix_ready) begin
          a = b + 11'(got);
          if (bus.pix_data !== mem[a]) data_err++;
          if (bus.pix_last !== (got % 4 == 3)) data_err++;
          got++;
        end
        prev_stall = bus.pix_valid && !bus.pix_ready;
        prev_d     = bus.pix_data;
        if (issued - got > max_out) max_out = issued - got;
        step();
      end
    end
    chk({tag, "_frame_done"}, 32'(fd), 32'd1);
    chk({tag, "_words"}, 32'(got), 32'd8);
    chk({tag, "_issues"}, 32'(issued), 32'd8);
    chk({tag, "_data_err"}, 32'(data_err), 32'd0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, "_hold_err"}, 32'(hold_err), 32'd0);
    chk({tag, "_max_le4"}, 32'(max_out <= 4), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    step();
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h1000 + 16'(i);
    reset = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0;
    bus.pix_ready = 1'b0; bus.ram_b_data_out = '0;
    #12;
    chk("rst_outputs", {bus.ram_b_address, bus.ram_b_clk_enable, bus.ram_b_reset, bus.pix_valid,
                        bus.pix_last, frame_done, busy}, 32'd0);
    chk("rst_data", 32'(bus.pix_data), 32'd0);
    reset = 1'b1;
    step();

    // basic frame, base 0, ready held 1
    start = 1'b1; base_addr = 11'h000; bus.pix_ready = 1'b1;
    step();
    start = 1'b0;
    chk("e0_busy_en_addr", {busy, bus.ram_b_clk_enable, 11'(bus.ram_b_address), bus.pix_valid},
        {1'b1, 1'b1, 11'h000, 1'b0});
    step();
    chk("e1_en_addr_valid", {bus.ram_b_clk_enable, 11'(bus.ram_b_address), bus.pix_valid},
        {1'b1, 11'h001, 1'b0});
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("word%0d", k), {bus.pix_valid, bus.pix_last, bus.pix_data, frame_done},
          {1'b1, (k % 4 == 3), 16'h1000 + 16'(k), 1'b0});
      step();
    end
    chk("done_pulse", {frame_done, busy, bus.pix_valid}, {1'b1, 1'b0, 1'b0});
    step();
    chk("done_one_cycle", 32'(frame_done), 32'd0);

    // address wrap, throttled/stalled consumer (stray start included)
    run_frame(11'h7FE, 0, "wrap");
    run_frame(11'h010, 1, "toggle");
    run_frame(11'h020, 2, "stall");

    // abort after 3 accepted words
    start = 1'b1; base_addr = 11'h000; bus.pix_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step(); step();
    chk("abort_pre_word3", 32'(bus.pix_data), 32'h1003);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_state", {busy, bus.pix_valid, bus.ram_b_clk_enable, frame_done}, 32'd0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (frame_done || bus.pix_valid || busy) bad++;
      step();
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    run_frame(11'h100, 0, "after_abort");

    // reset mid-frame
    start = 1'b1; base_addr = 11'h040; bus.pix_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_outputs", {bus.ram_b_address, bus.ram_b_clk_enable, bus.ram_b_reset, bus.pix_valid,
                           bus.pix_last, frame_done, busy}, 32'd0);
    chk("midrst_data", 32'(bus.pix_data), 32'd0);
    #1 reset = 1'b1;
    step();
    chk("midrst_idle", {busy, bus.pix_valid, bus.ram_b_clk_enable}, 32'd0);

    // byte order: bytes 'A','B' at port-A 0xFFE/0xFFF land in word 0x7FF
    mem[11'h7FF] = 16'h4241;
    start = 1'b1; base_addr = 11'h7FF; bus.pix_ready = 1'b0;
    step();
    start = 1'b0;
    step(); step();
`ifdef MULTIMEM_READER_BYTESWAP_EN
    chk("byte_order", {bus.pix_valid, bus.pix_data}, {1'b1, 16'h4142});
`else
    chk("byte_order", {bus.pix_valid, bus.pix_data}, {1'b1, 16'h4241});
`endif
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
